// File: rtl/small_mult_if.sv
// small_mult_if: valid/ready operand and result bundle for small_mult
interface small_mult_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0]   in0;
    logic [WIDTH-1:0]   in1;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] out0;
    logic               out_valid;
    modport master(output in0, in1, in_valid, input in_ready, out0, out_valid);
    modport slave(input in0, in1, in_valid, output in_ready, out0, out_valid);
endinterface

// File: rtl/small_mult.sv
// small_mult: iterative signed shift-add multiplier, one multiplier bit per clock
module small_mult #(
    parameter int WIDTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    small_mult_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t          state_q, state_d;
    logic [PW-1:0]   m_q, m_d, acc_q, acc_d, out0_q, out0_d, addend, sum;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d, start, last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_q         <= '0;
            q_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out0_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            q_q         <= q_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out0_q      <= out0_d;
            out_valid_q <= out_valid_d;
        end
    end
    always_comb begin
        start   = state_q == IDLE && bus.in_valid;
        last    = cnt_q == CW'(WIDTH - 1);
        state_d = start ? BUSY : (state_q == BUSY && last) ? IDLE : state_q;
    end
    // the sign bit of the multiplier carries weight -2^(W-1), so it subtracts
    always_comb begin
        addend      = m_q << cnt_q;
        sum         = !q_q[cnt_q] ? acc_q : last ? acc_q - addend : acc_q + addend;
        m_d         = start ? {{WIDTH{bus.in0[WIDTH-1]}}, bus.in0} : m_q;
        q_d         = start ? bus.in1 : q_q;
        acc_d       = state_q == BUSY ? sum : '0;
        cnt_d       = state_q == BUSY ? cnt_q + 1'b1 : '0;
        out0_d      = state_q == BUSY && last ? sum : out0_q;
        out_valid_d = state_q == BUSY && last;
    end
    always_comb begin
        bus.in_ready  = state_q == IDLE;
        bus.out0      = out0_q;
        bus.out_valid = out_valid_q;
    end
endmodule

// File: tb/tb_small_mult.sv
// tb_small_mult: directed scoreboard bench for small_mult
module tb_small_mult;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    typedef struct {logic [7:0] prod; int due;} exp_t;
    exp_t exp_q[$];
    logic [7:0] prev_out0 = '0;
    logic       prev_ov = 1'b0;

    small_mult_if #(.WIDTH(4)) ifc();
    small_mult #(.WIDTH(4)) dut(.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // monitor: pops the scoreboard on every result pulse and checks hold behaviour
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_out0 <= '0;
            prev_ov   <= 1'b0;
        end else begin
            if (ifc.out_valid) begin
                chk("pulse_width", {31'd0, prev_ov}, 32'd0);
                chk("ready_with_valid", {31'd0, ifc.in_ready}, 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("product", {24'd0, ifc.out0}, {24'd0, e.prod});
                    chk("latency", cyc, e.due);
                end
            end else begin
                chk("out0_hold", {24'd0, ifc.out0}, {24'd0, prev_out0});
            end
            prev_out0 <= ifc.out0;
            prev_ov   <= ifc.out_valid;
        end
    end

    task automatic send(input logic signed [3:0] a, input logic signed [3:0] b, input bit hold);
        int t;
        exp_t e;
        logic signed [7:0] p;
        t = 0;
        @(negedge clk);
        while (!ifc.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", 32'd1, 32'd0);
        ifc.in0 = a;
        ifc.in1 = b;
        ifc.in_valid = 1'b1;
        p = a * b;
        e.prod = p;
        e.due = cyc + 5;
        exp_q.push_back(e);
        if (!hold) begin
            @(negedge clk);
            ifc.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        ifc.in0 = '0;
        ifc.in1 = '0;
        ifc.in_valid = 1'b0;
        #1;
        chk("rst_out0", {24'd0, ifc.out0}, 32'd0);
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // basic: 2 x 3 with busy window observed
        send(4'sd2, 4'sd3, 1'b0);
        chk("busy_ready_1", {31'd0, ifc.in_ready}, 32'd0);
        @(negedge clk);
        chk("busy_ready_2", {31'd0, ifc.in_ready}, 32'd0);
        @(negedge clk);
        chk("busy_ready_3", {31'd0, ifc.in_ready}, 32'd0);
        drain();

        // signed and extreme vectors with hand-computed products
        send(-4'sd7, 4'sd4, 1'b0);
        drain();
        chk("m7x4_hand", {24'd0, ifc.out0}, 32'h0000_00E4);
        send(4'sd3, -4'sd5, 1'b0);
        drain();
        chk("3xm5_hand", {24'd0, ifc.out0}, 32'h0000_00F1);
        send(-4'sd3, -4'sd3, 1'b0);
        drain();
        chk("m3xm3_hand", {24'd0, ifc.out0}, 32'h0000_0009);
        send(-4'sd8, -4'sd8, 1'b0);
        drain();
        chk("m8xm8_hand", {24'd0, ifc.out0}, 32'h0000_0040);
        send(-4'sd8, 4'sd7, 1'b0);
        drain();
        chk("m8x7_hand", {24'd0, ifc.out0}, 32'h0000_00C8);
        send(4'sd7, 4'sd7, 1'b0);
        drain();
        chk("7x7_hand", {24'd0, ifc.out0}, 32'h0000_0031);
        send(4'sd0, -4'sd8, 1'b0);
        drain();
        chk("0xm8_hand", {24'd0, ifc.out0}, 32'h0000_0000);

        // busy-ignore: different operands offered while busy
        send(4'sd5, -4'sd2, 1'b0);
        ifc.in0 = 4'sd7;
        ifc.in1 = 4'sd7;
        ifc.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        ifc.in_valid = 1'b0;
        drain();
        repeat (6) @(negedge clk);
        chk("busy_ignore_out0", {24'd0, ifc.out0}, 32'h0000_00F6);

        // back-to-back exhaustive sweep with in_valid held high
        for (int a = -8; a < 8; a++)
            for (int b = -8; b < 8; b++)
                send(4'(a), 4'(b), 1'b1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        drain();

        // reset mid-operation
        send(4'sd5, 4'sd5, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_out0", {24'd0, ifc.out0}, 32'd0);
        chk("midrst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send(4'sd2, 4'sd3, 1'b0);
        drain();
        chk("post_rst_out0", {24'd0, ifc.out0}, 32'h0000_0006);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
